// File: rtl/clock_ratio_detector.sv
// clock_ratio_detector
//
// Receive-side companion to the clock divider. Samples a slow divided clock
// (div_clk) in the fast clk_in domain. Measures its period and, optionally, its
// high time in clk_in cycles. Reports lock once the period has been stable for
// LOCK_CNT consecutive matches. A stopped or too-slow div_clk raises a sticky
// overflow flag.
//
// Optional feature macro: CLKDET_DUTY_EN
//   defined   : high-time counter, falling-edge capture and high_time output are built
//   undefined : no high-time logic; high_time is tied to 0
//
// Parameters
//   CNT_W        width of the period/high-time counters and outputs
//   SYNC_STAGES  flops in the div_clk synchronizer (2..4)
//   LOCK_CNT     consecutive matching periods needed for lock (1..15)
//   TOL          max |period difference| (clk_in cycles) still counted as a match
//
// Ports
//   clk_in        in   fast reference clock, rising edge
//   rst           in   asynchronous active-high reset
//   div_clk       in   slow clock under measurement, asynchronous to clk_in
//   period        out  last measured div_clk period in clk_in cycles
//   high_time     out  last measured div_clk high time in clk_in cycles
//   period_valid  out  one-cycle pulse when period/high_time update
//   locked        out  period stable for LOCK_CNT consecutive matches
//   overflow      out  sticky: period counter saturated (div_clk stopped/too slow)

module clock_ratio_detector #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned TOL         = 0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W:0]   TolW    = (CNT_W + 1)'(TOL);
    localparam logic [3:0]       LockCnt = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        StWaitEdge = 2'd0,
        StMeasure  = 2'd1,
        StLocked   = 2'd2
    } state_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------
    // Synchronizer and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_prev_q;
    logic                   rise;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], div_clk};
            s_prev_q <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev_q;

    // ------------------------------------------------------------------
    // Period counter: cycles since last rise, saturating
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             sat;

    always_comb begin
        pcnt_d = pcnt_q;
        if (rise) begin
            pcnt_d = CntOne;
        end else if (pcnt_q != CntMax) begin
            pcnt_d = pcnt_q + CntOne;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    // A rise in the same cycle as saturation takes precedence.
    assign sat = (pcnt_q == CntMax) && !rise;

    // ------------------------------------------------------------------
    // Match test against the previously reported period
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W:0]   diff;
    logic [CNT_W:0]   abs_diff;
    logic             first_q, first_d;
    logic             match;
    logic [3:0]       mcnt_q, mcnt_d;
    logic [3:0]       mcnt_inc;

    // One extra bit so the subtraction never wraps.
    assign diff     = {1'b0, pcnt_q} - {1'b0, period_q};
    assign abs_diff = diff[CNT_W] ? -diff : diff;
    // The first measurement after WAIT_EDGE has nothing valid to compare against.
    assign match    = !first_q && (abs_diff <= TolW);
    assign mcnt_inc = mcnt_q + 4'd1;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= StWaitEdge;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitEdge: begin
                if (rise) begin
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                if (rise) begin
                    if (match && (mcnt_inc == LockCnt)) begin
                        state_d = StLocked;
                    end
                end else if (sat) begin
                    state_d = StWaitEdge;
                end
            end
            StLocked: begin
                if (rise) begin
                    if (!match) begin
                        state_d = StMeasure;
                    end
                end else if (sat) begin
                    state_d = StWaitEdge;
                end
            end
            default: state_d = StWaitEdge;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next-state logic
    // ------------------------------------------------------------------
    logic valid_q, valid_d;
    logic locked_q, locked_d;
    logic overflow_q, overflow_d;
    logic update;

    always_comb begin
        period_d   = period_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        overflow_d = overflow_q;
        mcnt_d     = mcnt_q;
        first_d    = first_q;
        update     = 1'b0;
        unique case (state_q)
            StWaitEdge: begin
                if (rise) begin
                    first_d = 1'b1;
                    mcnt_d  = '0;
                end
            end
            StMeasure: begin
                if (rise) begin
                    update   = 1'b1;
                    period_d = pcnt_q;
                    valid_d  = 1'b1;
                    first_d  = 1'b0;
                    if (match) begin
                        mcnt_d = mcnt_inc;
                        if (mcnt_inc == LockCnt) begin
                            locked_d = 1'b1;
                        end
                    end else begin
                        mcnt_d = '0;
                    end
                end else if (sat) begin
                    overflow_d = 1'b1;
                    locked_d   = 1'b0;
                    mcnt_d     = '0;
                end
            end
            StLocked: begin
                if (rise) begin
                    update   = 1'b1;
                    period_d = pcnt_q;
                    valid_d  = 1'b1;
                    first_d  = 1'b0;
                    if (!match) begin
                        locked_d = 1'b0;
                        mcnt_d   = '0;
                    end
                end else if (sat) begin
                    overflow_d = 1'b1;
                    locked_d   = 1'b0;
                    mcnt_d     = '0;
                end
            end
            default: begin
                locked_d = 1'b0;
                mcnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            period_q   <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
            mcnt_q     <= '0;
            first_q    <= 1'b1;
        end else begin
            period_q   <= period_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            overflow_q <= overflow_d;
            mcnt_q     <= mcnt_d;
            first_q    <= first_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign overflow     = overflow_q;

    // ------------------------------------------------------------------
    // High-time measurement
    // ------------------------------------------------------------------
`ifdef CLKDET_DUTY_EN
    logic             fall;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] hlat_q;
    logic [CNT_W-1:0] high_time_q;

    assign fall = ~s & s_prev_q;

    always_comb begin
        hcnt_d = hcnt_q;
        if (rise) begin
            hcnt_d = CntOne;
        end else if (s && (hcnt_q != CntMax)) begin
            hcnt_d = hcnt_q + CntOne;
        end
    end

    // hlat_q holds the completed high phase until the next rise publishes it.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hcnt_q      <= '0;
            hlat_q      <= '0;
            high_time_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            if (fall) begin
                hlat_q <= hcnt_q;
            end
            if (update) begin
                high_time_q <= hlat_q;
            end
        end
    end

    assign high_time = high_time_q;
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Scoreboard bench for clock_ratio_detector. Two instances (TOL=0 and TOL=1)
// watch the same div_clk. Every div_clk rise is fed to a per-instance
// reference model that works purely on rise times. When a measurement is due,
// the model queues the expected record. A monitor pops and compares on every
// period_valid.
`timescale 1ns/1ps

module tb_clock_ratio_detector;

    localparam int CW   = 8;
    localparam int SS   = 2;
    localparam int LC   = 4;
    localparam int MAXC = 255;
`ifdef CLKDET_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst;
    logic          div_clk;
    logic [CW-1:0] period0, high0, period1, high1;
    logic          valid0, locked0, ovf0, valid1, locked1, ovf1;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    clock_ratio_detector #(.CNT_W(CW), .SYNC_STAGES(SS), .LOCK_CNT(LC), .TOL(0)) u_dut0 (
        .clk_in      (clk_in),
        .rst         (rst),
        .div_clk     (div_clk),
        .period      (period0),
        .high_time   (high0),
        .period_valid(valid0),
        .locked      (locked0),
        .overflow    (ovf0)
    );

    clock_ratio_detector #(.CNT_W(CW), .SYNC_STAGES(SS), .LOCK_CNT(LC), .TOL(1)) u_dut1 (
        .clk_in      (clk_in),
        .rst         (rst),
        .div_clk     (div_clk),
        .period      (period1),
        .high_time   (high1),
        .period_valid(valid1),
        .locked      (locked1),
        .overflow    (ovf1)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit armed;      // a rise has been seen since reset/overflow
        bit have_prev;  // a period has been reported since arming
        bit locked;
        bit ovf;
        int prev;
        int run;
        int last;
        int last_high;
    } mdl_t;

    typedef struct {
        int cyc;
        int period;
        int high;
        bit locked;
        bit ovf;
    } exp_t;

    mdl_t m[2];
    exp_t q0[$];
    exp_t q1[$];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k].armed = 0; m[k].have_prev = 0; m[k].locked = 0; m[k].ovf = 0;
            m[k].prev = 0; m[k].run = 0; m[k].last = 0; m[k].last_high = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    // c: cycle number just before the first clk_in edge that samples the rise.
    function automatic void model_rise(int k, int c, int h, int tol);
        int gap;
        int d;
        exp_t e;
        gap = c - m[k].last;
        if (m[k].armed && gap > MAXC) begin
            m[k].ovf = 1; m[k].locked = 0; m[k].run = 0; m[k].armed = 0;
        end
        if (!m[k].armed) begin
            m[k].armed = 1; m[k].have_prev = 0; m[k].run = 0;
        end else begin
            d = gap - m[k].prev;
            if (d < 0) d = -d;
            if (m[k].have_prev && d <= tol) begin
                m[k].run++;
                if (m[k].run >= LC) m[k].locked = 1;
            end else begin
                m[k].run = 0; m[k].locked = 0;
            end
            m[k].have_prev = 1;
            m[k].prev = gap;
            e.cyc = c + 1 + SS;
            e.period = gap;
            e.high = DUTY ? m[k].last_high : 0;
            e.locked = m[k].locked;
            e.ovf = m[k].ovf;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        m[k].last = c;
        m[k].last_high = (h > MAXC) ? MAXC : h;
    endfunction

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void mon(int k, int p, int ht, int lk, int ov);
        exp_t e;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut%0d unexpected period_valid: got period %0d expected none (cycle %0d)",
                     k, p, cyc);
            return;
        end
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("dut%0d valid_cycle", k), cyc, e.cyc);
        chk($sformatf("dut%0d period", k), p, e.period);
        chk($sformatf("dut%0d high_time", k), ht, e.high);
        chk($sformatf("dut%0d locked", k), lk, int'(e.locked));
        chk($sformatf("dut%0d overflow", k), ov, int'(e.ovf));
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        if (!rst && valid0) mon(0, int'(period0), int'(high0), int'(locked0), int'(ovf0));
        if (!rst && valid1) mon(1, int'(period1), int'(high1), int'(locked1), int'(ovf1));
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input int h, input int l);
        @(negedge clk_in);
        div_clk = 1'b1;
        model_rise(0, cyc, h, 0);
        model_rise(1, cyc, h, 1);
        repeat (h) @(negedge clk_in);
        div_clk = 1'b0;
        repeat (l - 1) @(negedge clk_in);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) @(negedge clk_in);
        chk("drain_pending", q0.size() + q1.size(), 0);
    endtask

    initial begin
        int base;
        int h;
        int l;
        rst = 1'b1;
        div_clk = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        chk("rst period", int'(period0), 0);
        chk("rst high_time", int'(high0), 0);
        chk("rst valid", int'(valid0), 0);
        chk("rst locked", int'(locked0), 0);
        chk("rst overflow", int'(ovf0), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_in);

        // divide-by-20, then divide-by-12
        repeat (8) pulse(10, 10);
        drain();
        chk("div20 locked", int'(locked0), 1);
        chk("div20 overflow", int'(ovf0), 0);
        repeat (6) pulse(6, 6);
        drain();
        chk("div12 locked", int'(locked0), 1);

        // tolerance: 20/21 locks TOL=1 only, 20/22 unlocks it
        repeat (4) begin pulse(10, 10); pulse(10, 11); end
        drain();
        chk("tol1 20/21 locked", int'(locked1), 1);
        chk("tol0 20/21 locked", int'(locked0), 0);
        repeat (5) begin pulse(10, 10); pulse(10, 12); end
        drain();
        chk("tol1 20/22 locked", int'(locked1), 0);

        // random stable ratios with +0/+1 jitter, then fully random
        repeat (4) begin
            base = int'($urandom_range(8, 40));
            repeat (8) begin
                h = base / 2;
                l = base - h + int'($urandom_range(0, 1));
                pulse(h, l);
            end
        end
        repeat (20) pulse(int'($urandom_range(1, 15)), int'($urandom_range(1, 15)));
        drain();

        // period of exactly 2^CNT_W-1: measured, no overflow
        pulse(100, 155);
        pulse(100, 155);
        pulse(10, 10);
        drain();
        chk("max_period overflow", int'(ovf0), 0);

        // lock, then stop div_clk
        repeat (7) pulse(10, 10);
        drain();
        chk("pre_stop locked", int'(locked0), 1);
        repeat (300) @(negedge clk_in);
        chk("stop overflow", int'(ovf0), 1);
        chk("stop locked", int'(locked0), 0);
        chk("stop overflow tol1", int'(ovf1), 1);
        repeat (7) pulse(10, 10);
        drain();
        chk("restart locked", int'(locked0), 1);
        chk("restart overflow sticky", int'(ovf0), 1);

        // asynchronous reset mid-period while locked
        @(negedge clk_in);
        #3 rst = 1'b1;
        #1;
        chk("async_rst locked", int'(locked0), 0);
        chk("async_rst overflow", int'(ovf0), 0);
        chk("async_rst period", int'(period0), 0);
        chk("async_rst high_time", int'(high0), 0);
        chk("async_rst valid", int'(valid0), 0);
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        model_reset();
        repeat (3) pulse(10, 10);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clock_ratio_detector.md
Name: clock_ratio_detector

Overview:
- Receive-side companion to the clock divider.
- Samples a slow divided clock (div_clk) in the fast clk_in domain and measures its period and high time in clk_in cycles.
- Reports lock once the ratio is stable, for divider bring-up checks and clock-ratio self-test in the testbench and SoC.
- Flags loss of the slow clock through an overflow indication.

Parameters:
CNT_W, 8, width of period/high-time counters and outputs
SYNC_STAGES, 2, flip-flop stages in the div_clk synchronizer (legal range 2..4)
LOCK_CNT, 4, consecutive matching periods required to assert locked (legal range 1..15)
TOL, 0, allowed absolute difference in clk_in cycles between consecutive periods that still counts as a match

Ports:
clk_in  input  1  fast reference clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
div_clk  input  1  slow clock under measurement; asynchronous to clk_in
period  output  CNT_W  last measured full period of div_clk, in clk_in cycles
high_time  output  CNT_W  last measured div_clk high time, in clk_in cycles
period_valid  output  1  one-cycle pulse when period/high_time update
locked  output  1  ratio stable for LOCK_CNT consecutive matches
overflow  output  1  sticky; period counter saturated (div_clk stopped or too slow)

Behaviour:
- Reset (async, rst=1): period=0, high_time=0, period_valid=0, locked=0, overflow=0. Synchronizer, counters and match counter cleared. FSM enters WAIT_EDGE.
- Synchronizer: div_clk passes through SYNC_STAGES flops, giving s. A rising edge is detected when s=1 and the previous s=0. A detected edge is a one-cycle strobe, rise.
- Latency: a div_clk rising edge produces rise, and period_valid for that edge, exactly SYNC_STAGES+1 clk_in cycles later.
- Counters:
  - pcnt counts clk_in cycles since the last rise. On rise it loads 1; otherwise it increments, saturating at 2^CNT_W-1.
  - hcnt counts cycles with s=1. On rise it loads 1; otherwise it increments while s=1, holds while s=0, and saturates.
- FSM:
  - WAIT_EDGE: on rise go to MEASURE. No output update and no period_valid.
  - MEASURE: on rise, period<=pcnt, high_time<=hcnt latched at s falling, period_valid=1 for that cycle.
    - Match test: |pcnt - previous period| <= TOL. The first measurement after WAIT_EDGE never matches.
    - On match: match counter +1. When it reaches LOCK_CNT, set locked=1 and go to LOCKED.
    - On mismatch: match counter=0.
  - LOCKED: keeps updating period/high_time on each rise. A mismatch clears locked, zeroes the match counter and returns to MEASURE.
  - Any state except WAIT_EDGE: if pcnt reaches saturation, set overflow=1, clear locked and the match counter, and go to WAIT_EDGE. period is not updated.
- high_time latch: hcnt value captured on the synced falling edge into an internal register. That register is transferred to high_time on the next rise.
- overflow is sticky; only rst clears it.
- Simultaneous rise and saturation in the same cycle: rise wins. The measurement is taken with period = 2^CNT_W-1 and overflow is not set.
- Differences computed in CNT_W+1 bits; no wrap.
- rst mid-measurement discards partial counts; the first period after release is never reported.

Optional Feature:
- Macro CLKDET_DUTY_EN.
- Defined: high-time counter, falling-edge capture and the high_time output operate as described above.
- Undefined: hcnt and capture logic are not generated, and high_time is tied to 0. All other behaviour is identical.

Test Plan:
- div_clk toggling every 10 clk_in cycles (divide-by-20), default params -> first period_valid on the 2nd rise with period=20 and high_time=20'd10 (with CLKDET_DUTY_EN); period_valid is 1 cycle wide, SYNC_STAGES+1=3 cycles after the div_clk edge.
- Same stimulus -> locked rises on the period_valid of the 6th rise (1 unmatched + 4 matches) and stays 1; overflow=0.
- Locked at period 20, then switch to divide-by-12 -> next period_valid shows period=12 and locked drops the same cycle; relock after 4 further matching periods of 12.
- Locked, then hold div_clk low -> overflow=1 after pcnt saturates at 255; locked=0; FSM in WAIT_EDGE. Restarting div_clk gives no valid on its first rise, valid on its second; overflow stays 1 until rst.
- TOL=1, alternating periods 20/21 (with jitter) -> locked asserts. Alternating 20/22 -> locked never asserts.
- rst asserted asynchronously mid-period while locked -> all outputs 0 immediately, without waiting for a clk_in edge. After release, the first rise gives no period_valid.
